// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the parametrised single-port RAM (mem_rw_param) and
// its read pipeline (mem_rd_pipe):
//   - mem_state_e : clear-sweep FSM states (ST_CLEAR, ST_IDLE)
//   - CNT_W       : width of the accepted-access counters
//   - addr_w()    : address width for a given depth (clog2, minimum 1)
//   - rd_lat_ok() : legality of a read-latency setting (1 or 2)
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int CNT_W      = 32'sd16;
    localparam int RD_LAT_MIN = 32'sd1;
    localparam int RD_LAT_MAX = 32'sd2;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } mem_state_e;

    // Number of address bits needed to index 'depth' words (at least one bit).
    function automatic int addr_w(input int depth);
        int w;
        w = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < depth) begin
                w = i + 32'sd1;
            end
        end
        return w;
    endfunction

    // Only one- and two-cycle read latencies are supported.
    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// RD_LAT-stage valid/data shift register that delays the registered array
// read to the programmed latency. The last stage drives the block outputs, so
// rd and rvalid come straight from flops. Data stages only load when their
// incoming valid is set, which makes rd hold the last returned word between
// rvalid pulses.
// Ports:
//   clk     in   clock, posedge
//   rst_n   in   synchronous active-low clear of all stages (valid and data)
//   in_vld  in   a read word enters the pipe this cycle
//   in_dat  in   the read word
//   rvalid  out  one-cycle pulse, rd valid
//   rd      out  read data, held between pulses
// -----------------------------------------------------------------------------
module mem_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             rvalid,
    output logic [WIDTH-1:0] rd
);

    logic [RD_LAT-1:0] vld_r;
    logic [WIDTH-1:0]  dat_r       [RD_LAT];
    logic [RD_LAT-1:0] vld_chain_s;
    logic [WIDTH-1:0]  dat_chain_s [RD_LAT];

    // Input of each stage: the pipe input for stage 0, the previous stage otherwise.
    always_comb begin
        vld_chain_s    = {RD_LAT{1'b0}};
        dat_chain_s    = '{default: {WIDTH{1'b0}}};
        vld_chain_s[0] = in_vld;
        dat_chain_s[0] = in_dat;
        for (int i = 32'sd1; i < RD_LAT; i++) begin
            vld_chain_s[i] = vld_r[i-1];
            dat_chain_s[i] = dat_r[i-1];
        end
    end

    // Stage registers; data advances only alongside a valid word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r <= {RD_LAT{1'b0}};
            for (int i = 32'sd0; i < RD_LAT; i++) begin
                dat_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            vld_r <= vld_chain_s;
            for (int i = 32'sd0; i < RD_LAT; i++) begin
                if (vld_chain_s[i]) begin
                    dat_r[i] <= dat_chain_s[i];
                end
            end
        end
    end

    assign rvalid = vld_r[RD_LAT-1];
    assign rd     = dat_r[RD_LAT-1];

endmodule

// File: rtl/mem_rw_param.sv
// -----------------------------------------------------------------------------
// mem_rw_param
// Parametrised single-port synchronous RAM with byte-enable writes, a
// req/ready handshake, a configurable read latency (1 or 2) and an optional
// zero-fill sweep after reset. Holds the array, the clear FSM and the write
// logic; read latency is produced by mem_rd_pipe.
//
// Timing: a read accepted on edge A registers the array word on A, and
// rvalid/rd rise on edge A+RD_LAT. After reset, ready rises on the DEPTH-th
// edge following the first edge with rst_n high (sweep of DEPTH words, then
// one registered cycle for ready). Without the sweep ready rises on the
// first such edge.
//
// Optional feature: define MEM_CNT_EN to build the saturating accepted-read
// and accepted-write counters; otherwise rd_cnt and wr_cnt are tied to 0.
//
// Ports:
//   clk     in   clock, posedge
//   rst_n   in   synchronous active-low reset
//   req     in   access request, accepted when req && ready
//   we      in   1 = write, 0 = read
//   be      in   byte write enables (ignored on reads)
//   adr     in   word address
//   wd      in   write data
//   ready   out  block can accept a request this cycle
//   rd      out  read data, held between rvalid pulses
//   rvalid  out  one-cycle pulse marking rd valid
//   rd_cnt  out  accepted-read counter
//   wr_cnt  out  accepted-write counter
// -----------------------------------------------------------------------------
module mem_rw_param
    import mem_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 64,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [WIDTH/8-1:0]        be,
    input  logic [addr_w(DEPTH)-1:0]  adr,
    input  logic [WIDTH-1:0]          wd,
    output logic                      ready,
    output logic [WIDTH-1:0]          rd,
    output logic                      rvalid,
    output logic [CNT_W-1:0]          rd_cnt,
    output logic [CNT_W-1:0]          wr_cnt
);

    localparam int AW = addr_w(DEPTH);
    localparam int NB = WIDTH / 8;
    // An unsupported latency falls back to a single pipe stage.
    localparam int PIPE_LAT = rd_lat_ok(RD_LAT) ? RD_LAT : 32'sd1;
    localparam mem_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [WIDTH-1:0] mem_r [DEPTH];

    mem_state_e       state_r;
    mem_state_e       state_nxt_s;
    logic [AW-1:0]    clr_cnt_r;
    logic [AW-1:0]    clr_cnt_nxt_s;
    logic             clr_we_s;
    logic             ready_r;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             rdq_vld_r;
    logic [WIDTH-1:0] rdq_dat_r;

    // Requests are only taken while ready is high; anything else is dropped.
    assign wr_acc_s = req & ready_r & we;
    assign rd_acc_s = req & ready_r & ~we;
    assign ready    = ready_r;

    // Clear FSM next state: sweep every word once, then stay idle until reset.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        clr_we_s      = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clr_we_s      = 1'b1;
                clr_cnt_nxt_s = clr_cnt_r + 1'b1;
                if (clr_cnt_r == {AW{1'b1}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                state_nxt_s   = ST_IDLE;
                clr_cnt_nxt_s = clr_cnt_r;
            end
            default: begin
                state_nxt_s   = RST_STATE;
                clr_cnt_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    // FSM state, sweep pointer and ready; ready trails the idle state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= RST_STATE;
            clr_cnt_r <= {AW{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            ready_r   <= (state_r == ST_IDLE);
        end
    end

    // Array writes: sweep zeroes one word per cycle, otherwise byte-enabled writes.
    // Nothing is written on a reset edge, so a request racing reset is lost.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we_s) begin
                mem_r[clr_cnt_r] <= {WIDTH{1'b0}};
            end else if (wr_acc_s) begin
                for (int b = 32'sd0; b < NB; b++) begin
                    if (be[b]) begin
                        mem_r[adr][32'sd8*b +: 8] <= wd[32'sd8*b +: 8];
                    end
                end
            end
        end
    end

    // Registered array read; a write on the previous edge is already visible here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdq_vld_r <= 1'b0;
            rdq_dat_r <= {WIDTH{1'b0}};
        end else begin
            rdq_vld_r <= rd_acc_s;
            if (rd_acc_s) begin
                rdq_dat_r <= mem_r[adr];
            end
        end
    end

    mem_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (PIPE_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (rdq_vld_r),
        .in_dat (rdq_dat_r),
        .rvalid (rvalid),
        .rd     (rd)
    );

`ifdef MEM_CNT_EN
    logic [CNT_W-1:0] rd_cnt_r;
    logic [CNT_W-1:0] wr_cnt_r;

    // Saturating counters of accepted reads and writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_r <= {CNT_W{1'b0}};
            wr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (rd_acc_s && (rd_cnt_r != {CNT_W{1'b1}})) begin
                rd_cnt_r <= rd_cnt_r + 1'b1;
            end
            if (wr_acc_s && (wr_cnt_r != {CNT_W{1'b1}})) begin
                wr_cnt_r <= wr_cnt_r + 1'b1;
            end
        end
    end

    assign rd_cnt = rd_cnt_r;
    assign wr_cnt = wr_cnt_r;
`else
    assign rd_cnt = {CNT_W{1'b0}};
    assign wr_cnt = {CNT_W{1'b0}};
`endif

endmodule
